// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the modulo up/down counter.
//   UP / DOWN : values of the up_dn direction input
//   WRAP / SAT: values of the sat boundary-mode input
//   clamp_max : limits a value to an upper bound (used to clamp load_val to MODULUS-1)
package mod_updown_counter_pkg;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    localparam logic WRAP = 1'b0;
    localparam logic SAT  = 1'b1;

    // Computed in 32 bits so MODULUS-1 is representable even when MODULUS = 2**16.
    function automatic int unsigned clamp_max(input int unsigned val, input int unsigned max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/mod_updown_counter_counter_reg.sv
// WIDTH-bit D register with asynchronous active-high reset.
//   clk   : rising-edge clock
//   RESET : asynchronous active-high reset, forces q to 0
//   d     : next value
//   q     : registered value
module counter_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with wrap/saturate boundary modes.
//   clk      : clock, all state changes on the rising edge
//   RESET    : asynchronous active-high reset (q=0, wrap=0)
//   en       : count enable
//   up_dn    : 1 = increment, 0 = decrement
//   sat      : 1 = saturate at the boundary, 0 = wrap around
//   clr      : synchronous clear (highest priority)
//   load     : synchronous load of load_val (clamped to MODULUS-1)
//   load_val : value to load
//   q        : current count, always within 0..MODULUS-1
//   tc       : terminal count, en and at the boundary in the current direction
//   wrap     : registered pulse, high in the cycle after a wrap-around edge
//   at_max   : q == MODULUS-1
//   at_zero  : q == 0
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_d, count_q;
    logic             wrap_d, wrap_q;

    assign at_max  = (count_q == MaxVal);
    assign at_zero = (count_q == '0);
    assign tc      = en & ((up_dn & at_max) | (~up_dn & at_zero));

    // Priority clr > load > en; wrap_d defaults low so only a wrap-around edge raises it.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = WIDTH'(clamp_max(32'(load_val), MODULUS - 1));
        end else if (en) begin
            if (up_dn == UP) begin
                if (at_max) begin
                    if (sat == WRAP) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    if (sat == WRAP) begin
                        count_d = MaxVal;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    counter_reg #(
        .WIDTH(WIDTH)
    ) u_count_reg (
        .clk  (clk),
        .RESET(RESET),
        .d    (count_d),
        .q    (count_q)
    );

    // wrap is registered alongside the count so it coincides with the post-wrap value.
    counter_reg #(
        .WIDTH(1)
    ) u_wrap_reg (
        .clk  (clk),
        .RESET(RESET),
        .d    (wrap_d),
        .q    (wrap_q)
    );

    assign q    = count_q;
    assign wrap = wrap_q;

endmodule
